// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core: decodes load-use, memory wait,
// branch and trap/mret events into per-stage register enables and bubble-insertion clears.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       uses_rs1_id,
    input  logic       uses_rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       is_LS_ex,
    input  logic       we_mem_ex,
    input  logic       we_wb_ex,
    input  logic       mem_req_mem,
    input  logic       mem_ack_i,
    input  logic       branch_taken_ex,
    input  logic       is_trap_ex,
    input  logic       is_mret_ex,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       ifid_clear,
    output logic       idex_clear,
    output logic       exmem_clear,
    output logic       memwb_clear,
    output logic       bus_err_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_CYCLES);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic ifid_clr_c, idex_clr_c, exmem_clr_c, memwb_clr_c, bus_err_c;
    logic load_use, mem_stall;

    assign load_use = is_LS_ex & ~we_mem_ex & we_wb_ex & (rd_ex != 5'd0) &
                      ((uses_rs1_id & (rs1_id == rd_ex)) | (uses_rs2_id & (rs2_id == rd_ex)));
    assign mem_stall = mem_req_mem & ~mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_en_c     = 1'b1;
        ifid_en_c   = 1'b1;
        idex_en_c   = 1'b1;
        exmem_en_c  = 1'b1;
        ifid_clr_c  = 1'b0;
        idex_clr_c  = 1'b0;
        exmem_clr_c = 1'b0;
        memwb_clr_c = 1'b0;
        bus_err_c   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    pc_en_c     = 1'b0;
                    ifid_en_c   = 1'b0;
                    idex_en_c   = 1'b0;
                    exmem_en_c  = 1'b0;
                    memwb_clr_c = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = WW'(1);
                end else if (is_trap_ex | is_mret_ex) begin
                    // PC loads the redirect target this cycle; everything younger is squashed.
                    ifid_clr_c  = 1'b1;
                    idex_clr_c  = 1'b1;
                    exmem_clr_c = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FW'(1);
                end else if (branch_taken_ex) begin
                    ifid_clr_c = 1'b1;
                    idex_clr_c = 1'b1;
                end else if (load_use) begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_clr_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    pc_en_c     = 1'b0;
                    ifid_en_c   = 1'b0;
                    idex_en_c   = 1'b0;
                    exmem_en_c  = 1'b0;
                    memwb_clr_c = 1'b1;
                    wait_cnt_d  = wait_cnt_q + WW'(1);
                end else begin
                    // Timeout: drop the stuck access and recover through the flush window.
                    bus_err_c   = 1'b1;
                    pc_en_c     = 1'b0;
                    ifid_en_c   = 1'b0;
                    idex_en_c   = 1'b0;
                    exmem_clr_c = 1'b1;
                    memwb_clr_c = 1'b1;
                    state_d     = ST_FLUSH;
                    wait_cnt_d  = '0;
                    flush_cnt_d = FW'(1);
                end
            end
            ST_FLUSH: begin
                pc_en_c    = 1'b0;
                ifid_clr_c = 1'b1;
                idex_clr_c = 1'b1;
                if (flush_cnt_q >= FLUSH_MAX) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                wait_cnt_d  = '0;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    assign pc_en       = rst_ni & pc_en_c;
    assign ifid_en     = rst_ni & ifid_en_c;
    assign idex_en     = rst_ni & idex_en_c;
    assign exmem_en    = rst_ni & exmem_en_c;
    assign ifid_clear  = rst_ni & ifid_clr_c;
    assign idex_clear  = rst_ni & idex_clr_c;
    assign exmem_clear = rst_ni & exmem_clr_c;
    assign memwb_clear = rst_ni & memwb_clr_c;
    assign bus_err_o   = rst_ni & bus_err_c;
    assign state_o     = rst_ni ? state_q : 2'd0;

endmodule
